// File: rtl/cache_mem_responder.sv
// cache_mem_responder: miss-path main memory with fixed access latency,
// block-burst reads and single-word writes.
module cache_mem_responder #(
    parameter int ADDR_W      = 15,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int LATENCY     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           readMem,
    input  logic                           writeMem,
    input  logic [ADDR_W-1:0]              addr,
    input  logic [WORD_W-1:0]              wdata,
    output logic                           busy,
    output logic                           dataValid,
    output logic [WORD_W-1:0]              rdata,
    output logic [$clog2(BLOCK_WORDS)-1:0] wordIdx,
    output logic                           blockDone
);
    localparam int IW    = $clog2(BLOCK_WORDS);
    localparam int CW    = LATENCY > 1 ? $clog2(LATENCY) : 1;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, WRITE} state_t;

    state_t            state, state_n;
    logic              op_wr, op_wr_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [IW-1:0]     idx, idx_n;
    logic [ADDR_W-1:0] a, a_n, rd_addr;
    logic [WORD_W-1:0] wd, wd_n;
    logic              last, lat_done, commit;

    // Unwritten words read back as their own address, so only a written flag
    // needs a power-up value; rst leaves both arrays alone.
    logic [WORD_W-1:0] mem [DEPTH];
    logic              written [DEPTH] = '{default: 1'b0};

    assign last     = idx == IW'(BLOCK_WORDS - 1);
    assign lat_done = cnt == CW'(LATENCY - 1);
    assign commit   = state == WAIT && op_wr && lat_done;
    assign rd_addr  = {a[ADDR_W-1:IW], idx};

    always_comb begin
        state_n = state;
        op_wr_n = op_wr;
        cnt_n   = cnt;
        idx_n   = idx;
        a_n     = a;
        wd_n    = wd;
        case (state)
            IDLE: begin
                if (readMem || writeMem) begin
                    state_n = WAIT;
                    op_wr_n = !readMem;
                    cnt_n   = '0;
                    a_n     = readMem ? addr & ~ADDR_W'(BLOCK_WORDS - 1) : addr;
                    wd_n    = readMem ? wd : wdata;
                end
            end
            WAIT: begin
                state_n = lat_done ? (op_wr ? WRITE : BURST) : WAIT;
                cnt_n   = lat_done ? '0 : cnt + 1'b1;
                idx_n   = '0;
            end
            BURST: begin
                state_n = last ? IDLE : BURST;
                idx_n   = last ? '0 : idx + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            op_wr <= 1'b0;
            cnt   <= '0;
            idx   <= '0;
            a     <= '0;
            wd    <= '0;
        end else begin
            state <= state_n;
            op_wr <= op_wr_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            a     <= a_n;
            wd    <= wd_n;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[a]     <= wd;
            written[a] <= 1'b1;
        end
    end

    assign busy      = state != IDLE;
    assign dataValid = state == BURST;
    assign wordIdx   = dataValid ? idx : '0;
    assign blockDone = (state == BURST && last) || state == WRITE;
    assign rdata     = !dataValid ? '0 : written[rd_addr] ? mem[rd_addr] : WORD_W'(rd_addr);
endmodule

// File: tb/tb_cache_mem_responder.sv
// tb_cache_mem_responder: randomized self-checking bench with a cycle-level
// reference model derived from the responder's timing rules.
module tb_cache_mem_responder;
    localparam int ADDR_W = 15;
    localparam int WORD_W = 32;
    localparam int BW     = 4;
    localparam int L      = 4;
    localparam int IW     = $clog2(BW);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int P      = L + BW + 1;
    localparam int OW     = 3 + IW + WORD_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              readMem = 1'b0;
    logic              writeMem = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [WORD_W-1:0] wdata = '0;
    logic              busy, dataValid, blockDone;
    logic [WORD_W-1:0] rdata;
    logic [IW-1:0]     wordIdx;
    logic [OW-1:0]     obs, exp;

    logic [WORD_W-1:0] model [DEPTH];
    int checks = 0;
    int errors = 0;

    cache_mem_responder #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .BLOCK_WORDS(BW), .LATENCY(L)) dut (
        .clk(clk), .rst(rst), .readMem(readMem), .writeMem(writeMem), .addr(addr),
        .wdata(wdata), .busy(busy), .dataValid(dataValid), .rdata(rdata),
        .wordIdx(wordIdx), .blockDone(blockDone)
    );

    always #5 clk = ~clk;

    assign obs = {busy, dataValid, wordIdx, rdata, blockDone};

    // Expected outputs n cycles after a read of block 'base' is accepted.
    function automatic logic [OW-1:0] exp_read(input int base, input int n);
        logic dv;
        logic [IW-1:0] i;
        logic [WORD_W-1:0] d;
        dv = n > L && n <= L + BW;
        i = '0;
        d = '0;
        if (dv) begin
            i = IW'(n - L - 1);
            d = model[base + n - L - 1];
        end
        return {n <= L + BW, dv, i, d, n == L + BW};
    endfunction

    function automatic logic [OW-1:0] exp_write(input int n);
        return {n <= L + 1, 1'b0, {IW{1'b0}}, {WORD_W{1'b0}}, n == L + 1};
    endfunction

    task automatic issue(input logic rd, input logic wr, input int a, input logic [WORD_W-1:0] d);
        @(negedge clk);
        readMem = rd;
        writeMem = wr;
        addr = ADDR_W'(a);
        wdata = d;
        @(posedge clk);
        #1 readMem = 1'b0;
        writeMem = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (obs !== '0) begin errors++; $display("FAIL reset: got %h expected 0", obs); end
        end
        rst = 1'b1;
    endtask

    task automatic test_read();
        int a, base;
        for (int t = 0; t < 5; t++) begin
            a = t == 0 ? 'h12 : int'($urandom_range(0, DEPTH - 1));
            base = a & ~(BW - 1);
            issue(1'b1, 1'b0, a, '0);
            for (int n = 1; n <= P; n++) begin
                @(negedge clk);
                exp = exp_read(base, n);
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL read a=%h n=%0d: got %h expected %h", a, n, obs, exp); end
            end
        end
    endtask

    task automatic test_write();
        int a, base;
        logic [WORD_W-1:0] d;
        for (int t = 0; t < 4; t++) begin
            a = t == 0 ? 'h101 : int'($urandom_range(0, DEPTH - 1));
            d = t == 0 ? 32'hDEADBEEF : $urandom;
            issue(1'b0, 1'b1, a, d);
            for (int n = 1; n <= L + 2; n++) begin
                @(negedge clk);
                exp = exp_write(n);
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL write a=%h n=%0d: got %h expected %h", a, n, obs, exp); end
            end
            model[a] = d;
            base = a & ~(BW - 1);
            issue(1'b1, 1'b0, base, '0);
            for (int n = 1; n <= P; n++) begin
                @(negedge clk);
                exp = exp_read(base, n);
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL write_readback a=%h n=%0d: got %h expected %h", a, n, obs, exp); end
            end
        end
    endtask

    task automatic test_collision();
        for (int t = 0; t < 2; t++) begin
            issue(1'b1, t == 0, 'h40, 32'h5);
            for (int n = 1; n <= P; n++) begin
                @(negedge clk);
                exp = exp_read('h40, n);
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL collision pass=%0d n=%0d: got %h expected %h", t, n, obs, exp); end
            end
        end
    endtask

    task automatic test_ignore();
        issue(1'b1, 1'b0, 'h200, '0);
        for (int n = 1; n <= P + 6; n++) begin
            @(negedge clk);
            exp = n <= P ? exp_read('h200, n) : '0;
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL ignore n=%0d: got %h expected %h", n, obs, exp); end
            if (n == L + 2) begin readMem = 1'b1; addr = 'h300; end
            if (n == L + 3) readMem = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int a, base;
        a = $urandom_range(0, DEPTH - 1);
        base = a & ~(BW - 1);
        @(negedge clk);
        readMem = 1'b1;
        addr = ADDR_W'(a);
        @(posedge clk);
        for (int n = 1; n <= 3 * P + 3; n++) begin
            @(negedge clk);
            exp = n <= 3 * P ? exp_read(base, (n - 1) % P + 1) : '0;
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL back_to_back n=%0d: got %h expected %h", n, obs, exp); end
            if (n == 3 * P - 1) readMem = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int a, base, wa, wbase;
        a = $urandom_range(0, DEPTH - 1);
        base = a & ~(BW - 1);
        issue(1'b1, 1'b0, a, '0);
        for (int n = 1; n <= L + 2; n++) begin
            @(negedge clk);
            exp = exp_read(base, n);
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL reset_mid_pre n=%0d: got %h expected %h", n, obs, exp); end
        end
        #2 rst = 1'b0;
        #1 checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_mid_async: got %h expected 0", obs); end
        @(negedge clk);
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (obs !== '0) begin errors++; $display("FAIL reset_mid_idle: got %h expected 0", obs); end
        end
        wa = $urandom_range(0, DEPTH - 1);
        wbase = wa & ~(BW - 1);
        issue(1'b0, 1'b1, wa, ~model[wa]);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int t = 0; t < 2; t++) begin
            issue(1'b1, 1'b0, t == 0 ? wbase : base, '0);
            for (int n = 1; n <= P; n++) begin
                @(negedge clk);
                exp = exp_read(t == 0 ? wbase : base, n);
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL reset_mid_mem t=%0d n=%0d: got %h expected %h", t, n, obs, exp); end
            end
        end
    endtask

    task automatic test_top_block();
        issue(1'b1, 1'b0, 'h7FFE, '0);
        for (int n = 1; n <= P; n++) begin
            @(negedge clk);
            exp = exp_read('h7FFC, n);
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL top_block n=%0d: got %h expected %h", n, obs, exp); end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = WORD_W'(i);
        test_reset();
        test_read();
        test_write();
        test_collision();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        test_top_block();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_mem_responder.md
# cache_mem_responder

Main-memory responder on the miss path of the direct-mapped cache. Accepts block-read and single-word write requests from the cache controller, waits a fixed access latency, then answers. Reads return one cache block as a burst of one word per cycle, which the controller writes into the cache line. Holds the backing word array, which is initialised at elaboration so benches have known contents.

## Interface
Parameters:
- ADDR_W, 15, word-address width; memory depth is 2^ADDR_W words
- WORD_W, 32, data word width
- BLOCK_WORDS, 4, words per cache block; power of 2, at least 2
- LATENCY, 4, wait cycles between request acceptance and response; at least 1

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- readMem  in  1  block-read request, level, sampled only in IDLE
- writeMem  in  1  word-write request, level, sampled only in IDLE
- addr  in  ADDR_W  word address of the request
- wdata  in  WORD_W  write data
- busy  out  1  high in every state except IDLE
- dataValid  out  1  rdata and wordIdx are valid this cycle
- rdata  out  WORD_W  burst read word
- wordIdx  out  log2(BLOCK_WORDS)  offset of the current word within the block
- blockDone  out  1  one-cycle pulse: last burst word, or write committed

## Operation
- States: IDLE, WAIT, BURST, WRITE.
- IDLE, on a rising edge:
  - readMem=1: latch base = addr with the low log2(BLOCK_WORDS) bits cleared, clear the latency counter, go to WAIT with op=read.
  - writeMem=1 and readMem=0: latch addr and wdata, go to WAIT with op=write.
  - Both high: the read wins and the write is dropped.
  - Neither high: stay in IDLE.
- WAIT: the counter increments each cycle. When it reaches LATENCY-1:
  - op=read: go to BURST with word counter i=0.
  - op=write: commit mem[addr] <= wdata on that edge and go to WRITE.
- BURST: dataValid=1, wordIdx=i, rdata=mem[base+i].
  - i < BLOCK_WORDS-1: i increments.
  - i = BLOCK_WORDS-1: blockDone=1, go to IDLE next edge.
- WRITE: blockDone=1 for exactly one cycle, then go to IDLE.
- readMem and writeMem are ignored in every state except IDLE. A request held high through blockDone is accepted again in the following IDLE cycle.
- Address arithmetic: base+i stays inside the aligned block and never carries into the tag bits. The top block ends at address 2^ADDR_W-1 with no wrap.
- Memory contents at elaboration: mem[a] = a, zero-extended to WORD_W.
  - rst does not clear memory; contents persist across resets.
  - A read after a write to the same address returns the written data.
- Outputs are Moore, decoded from registered state and counters only. No combinational path from any input to any output.
- rdata is 0 whenever dataValid=0.

## Timing
- Reset (rst=0, asynchronous): state IDLE, counters 0, busy=0, dataValid=0, rdata=0, wordIdx=0, blockDone=0.
- Reset mid-burst or mid-wait aborts immediately. No further dataValid or blockDone until a new request.
- A write aborted before its commit edge leaves memory unchanged.
- Read accepted on edge k:
  - busy=1 from cycle k+1.
  - First dataValid in cycle k+1+LATENCY.
  - Last word, with blockDone, in cycle k+LATENCY+BLOCK_WORDS.
  - IDLE in the next cycle.
- Write accepted on edge k:
  - Memory is updated on edge k+LATENCY.
  - blockDone in cycle k+1+LATENCY.
  - IDLE in the next cycle.
- Minimum spacing of back-to-back reads: LATENCY+BLOCK_WORDS+1 cycles from one acceptance edge to the next.

## Test plan
- Reset, then readMem=1 with addr=0x0012 held for one cycle: busy rises, then 4 wait cycles. dataValid for 4 cycles with wordIdx 0,1,2,3 and rdata 0x10,0x11,0x12,0x13. blockDone coincides with 0x13, then busy=0.
- writeMem with addr=0x0101, wdata=0xDEADBEEF: blockDone 5 cycles after acceptance. A following read of addr=0x0100 returns 0x100, 0xDEADBEEF, 0x102, 0x103.
- readMem and writeMem high together, addr=0x0040, wdata=0x5: a read burst of 0x40..0x43 occurs and mem[0x40] stays 0x40.
- readMem pulsed during an active burst: ignored, with no second burst. readMem held high continuously: bursts repeat with acceptance edges exactly 9 cycles apart.
- rst driven low during the 2nd burst word: all outputs are 0 asynchronously. After release there is no dataValid without a new request, and memory is unchanged.
- Top block, addr=0x7FFE: rdata 0x7FFC..0x7FFF, with no wrap to 0x0000.
